// File: rtl/vote_input_conditioner.sv
// Ballot front-end: synchronizes and debounces three buttons, arbitrates a settle window and
// emits one registered single-cycle vote or invalid pulse per ballot.
module vote_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned SETTLE_CYCLES   = 2,
   parameter int unsigned LOCKOUT_CYCLES  = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_A,
   input  logic btn_B,
   input  logic btn_C,
   output logic vote_A,
   output logic vote_B,
   output logic vote_C,
   output logic invalid_vote,
   output logic ready
);

   localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int unsigned TmrMax = (SETTLE_CYCLES > LOCKOUT_CYCLES) ? SETTLE_CYCLES
                                                                     : LOCKOUT_CYCLES;
   localparam int unsigned TmrW   = $clog2(TmrMax) + 1;

   localparam logic [CntW-1:0] CntLast    = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TmrW-1:0] SettleLast = TmrW'(SETTLE_CYCLES - 1);
   localparam logic [TmrW-1:0] LockLast   = TmrW'(LOCKOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StArb,
      StRelease,
      StLockout
   } state_e;

   logic [2:0]           btn_raw;
   logic [2:0]           sync1_q, sync2_q;
   logic [2:0]           db_q, db_d;
   logic [2:0][CntW-1:0] cnt_q, cnt_d;

   state_e               state_q, state_d;
   logic [2:0]           mask_q, mask_d;
   logic [2:0]           merged;
   logic [TmrW-1:0]      timer_q, timer_d;
   logic [2:0]           vote_q, vote_d;
   logic                 invalid_q, invalid_d;
   logic                 ready_q, ready_d;

   assign btn_raw = {btn_C, btn_B, btn_A};
   assign merged  = mask_q | db_q;

   always_comb begin
      db_d  = db_q;
      cnt_d = cnt_q;
      for (int i = 0; i < 3; i++) begin
         if (sync2_q[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntLast) begin
            db_d[i]  = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      timer_d   = timer_q;
      vote_d    = '0;
      invalid_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (|db_q) begin
               state_d = StArb;
               mask_d  = db_q;
               timer_d = SettleLast;
            end
         end
         StArb: begin
            mask_d = merged;
            if (timer_q != '0) begin
               timer_d = timer_q - 1'b1;
            end else begin
               state_d = StRelease;
               // The pulse lands on the first cycle spent in StRelease.
               unique case (merged)
                  3'b000:  ;
                  3'b001:  vote_d = 3'b001;
                  3'b010:  vote_d = 3'b010;
                  3'b100:  vote_d = 3'b100;
                  default: invalid_d = 1'b1;
               endcase
            end
         end
         StRelease: begin
            if (db_q == 3'b000) begin
               state_d = StLockout;
               timer_d = LockLast;
            end
         end
         StLockout: begin
            if (|db_q) begin
               state_d = StRelease;
            end else if (timer_q == '0) begin
               state_d = StIdle;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ready is registered so it stays low while reset is held, despite the state being idle.
   assign ready_d = (state_d == StIdle);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         db_q      <= '0;
         cnt_q     <= '0;
         state_q   <= StIdle;
         mask_q    <= '0;
         timer_q   <= '0;
         vote_q    <= '0;
         invalid_q <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         sync1_q   <= btn_raw;
         sync2_q   <= sync1_q;
         db_q      <= db_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         mask_q    <= mask_d;
         timer_q   <= timer_d;
         vote_q    <= vote_d;
         invalid_q <= invalid_d;
         ready_q   <= ready_d;
      end
   end

   assign vote_A       = vote_q[0];
   assign vote_B       = vote_q[1];
   assign vote_C       = vote_q[2];
   assign invalid_vote = invalid_q;
   assign ready        = ready_q;

endmodule

// File: tb/tb_vote_input_conditioner.sv
// Scoreboard bench: ballots are predicted from press offsets and pushed to a queue; a monitor
// pops one entry for every observed pulse and checks its kind and cycle.
module tb_vote_input_conditioner;

   localparam int D = 4;
   localparam int S = 2;
   localparam int L = 8;

   typedef struct packed {
      int kind;   // 0=A 1=B 2=C 3=invalid
      int at;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic btn_A, btn_B, btn_C;
   logic vote_A, vote_B, vote_C, invalid_vote, ready;
   logic [3:0] outs_w;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   got_cnt [4] = '{0, 0, 0, 0};
   int   exp_cnt [4] = '{0, 0, 0, 0};
   exp_t sbq [$];
   int   b_off  [3];
   int   b_hold [3];

   vote_input_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .SETTLE_CYCLES  (S),
      .LOCKOUT_CYCLES (L)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_A       (btn_A),
      .btn_B       (btn_B),
      .btn_C       (btn_C),
      .vote_A      (vote_A),
      .vote_B      (vote_B),
      .vote_C      (vote_C),
      .invalid_vote(invalid_vote),
      .ready       (ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign outs_w = {invalid_vote, vote_C, vote_B, vote_A};

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int kind_of(input logic [3:0] o);
      return $clog2(o);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_pulse(input int kind, input int at);
      sbq.push_back('{kind: kind, at: at});
      exp_cnt[kind]++;
   endtask

   // Monitor: every pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (reset && outs_w != 4'b0000) begin
         check("pulse_onehot", $countones(outs_w), 1);
         if (sbq.size() == 0) begin
            check("unexpected_pulse", int'(outs_w), 0);
         end else begin
            check("pulse_kind", kind_of(outs_w), sbq[0].kind);
            check("pulse_cycle", cyc, sbq[0].at);
            void'(sbq.pop_front());
         end
         got_cnt[kind_of(outs_w)] <= got_cnt[kind_of(outs_w)] + 1;
      end
   end

   // One ballot from b_off/b_hold for the buttons in sel. A button counts if its press
   // starts no more than S cycles after the earliest press; the pulse follows 2+D+S edges
   // after the earliest press is first sampled.
   task automatic ballot(input logic [2:0] sel);
      int base, smin, maxend, npress, kind;
      base   = cyc;
      smin   = 1000;
      maxend = 0;
      npress = 0;
      kind   = 0;
      for (int i = 0; i < 3; i++) begin
         if (sel[i]) begin
            if (b_off[i] < smin) smin = b_off[i];
            if (b_off[i] + b_hold[i] > maxend) maxend = b_off[i] + b_hold[i];
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (sel[i] && b_off[i] <= smin + S) begin
            npress++;
            kind = i;
         end
      end
      if (npress > 0) expect_pulse((npress > 1) ? 3 : kind, base + smin + 1 + 2 + D + S);
      check("ready_before_ballot", int'(ready), 1);
      for (int t = 0; t <= maxend; t++) begin
         btn_A = sel[0] && t >= b_off[0] && t < b_off[0] + b_hold[0];
         btn_B = sel[1] && t >= b_off[1] && t < b_off[1] + b_hold[1];
         btn_C = sel[2] && t >= b_off[2] && t < b_off[2] + b_hold[2];
         if (npress > 0 && t == smin + 10) check("ready_busy", int'(ready), 0);
         tick(1);
      end
      tick(2 + D + L + 6);
      check("ready_after_ballot", int'(ready), 1);
   endtask

   task automatic single(input int b, input int hold);
      for (int i = 0; i < 3; i++) begin
         b_off[i]  = 0;
         b_hold[i] = hold;
      end
      ballot(3'(1 << b));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d checks", checks);
      $fatal(1);
   end

   initial begin
      int base;
      reset = 1'b0;
      btn_A = 1'b0;
      btn_B = 1'b0;
      btn_C = 1'b0;
      tick(3);
      check("reset_ready", int'(ready), 0);
      check("reset_outs", int'(outs_w), 0);
      reset = 1'b1;
      tick(1);
      check("ready_after_reset", int'(ready), 1);
      tick(3);

      // Single press A, then simultaneous and staggered A+B.
      single(0, 20);
      b_off  = '{0, 0, 0};
      b_hold = '{20, 20, 20};
      ballot(3'b011);
      b_off  = '{0, 1, 0};
      ballot(3'b011);

      // Glitches on B shorter than the debounce time.
      for (int k = 0; k < 3; k++) begin
         btn_B = 1'b1;
         tick(1);
         btn_B = 1'b0;
         tick(2);
      end
      for (int k = 0; k < 4; k++) begin
         btn_C = 1'b1;
         tick($urandom_range(1, D - 1));
         btn_C = 1'b0;
         tick($urandom_range(2, 4));
      end
      tick(D + 4);
      check("ready_after_glitch", int'(ready), 1);

      // Long C hold, then a press during lockout is ignored.
      base  = cyc;
      btn_C = 1'b1;
      expect_pulse(2, base + 1 + 2 + D + S);
      tick(100);
      btn_C = 1'b0;
      tick(6);
      btn_A = 1'b1;
      tick(10);
      btn_A = 1'b0;
      tick(25);
      check("ready_after_lockout_press", int'(ready), 1);
      single(0, 15);

      // Reset while arbitrating; A stays held across reset release.
      btn_A = 1'b1;
      tick(7);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         check("midreset_outs", int'(outs_w), 0);
         check("midreset_ready", int'(ready), 0);
      end
      reset = 1'b1;
      expect_pulse(0, cyc + 1 + 2 + D + S);
      tick(1);
      check("ready_after_midreset", int'(ready), 1);
      tick(14);
      btn_A = 1'b0;
      tick(25);
      check("ready_after_reset_ballot", int'(ready), 1);

      // Back-to-back A, B, C, A.
      single(0, 15);
      single(1, 15);
      single(2, 15);
      single(0, 15);

      // Random ballots with staggered press offsets around the settle boundary.
      for (int k = 0; k < 14; k++) begin
         for (int i = 0; i < 3; i++) begin
            b_off[i]  = $urandom_range(0, 4);
            b_hold[i] = $urandom_range(12, 30);
         end
         ballot(3'($urandom_range(1, 7)));
      end

      tick(30);
      check("scoreboard_empty", sbq.size(), 0);
      check("count_A", got_cnt[0], exp_cnt[0]);
      check("count_B", got_cnt[1], exp_cnt[1]);
      check("count_C", got_cnt[2], exp_cnt[2]);
      check("count_invalid", got_cnt[3], exp_cnt[3]);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
